alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised successor to the single-cycle datapath ALU.
- Adds a valid/ready handshake, registered results, and a clean zero flag valid for every op.
- Adds an iterative multi-cycle multiply/divide engine (shift-add multiply, restoring divide).
- Sits in the EX stage; the pipeline stalls on in_ready=0 or out_valid=0.

Parameters:
- WIDTH, 32, operand/result width; power of two, >= 8.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request this cycle.
- op  in  4  operation code (encoding below).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  x/zero hold a result.
- out_ready  in  1  consumer takes the result this cycle.
- x  out  WIDTH  result, registered.
- zero  out  1  1 when x == 0, registered with x.

Behaviour:
- Op encoding:
  - 0 AND, 1 OR, 2 NOR, 3 XOR, 4 ADD, 5 SUB (both modulo 2^WIDTH).
  - 6 SLTU (unsigned a<b -> 1 else 0); 7 SLT (two's-complement a<b).
  - 8 SLL, 9 SRL, 10 SRA (shift a by b[SHW-1:0]; upper bits of b ignored).
  - 11 MUL (low WIDTH bits of a*b, unsigned); 12 MULHU (high WIDTH bits).
  - 13 DIVU (a/b); 14 REMU (a%b); 15 reserved -> x=0.
- States: IDLE, BUSY, DONE. Accept = in_valid & in_ready.
- in_ready = (state==IDLE) | (state==DONE & out_ready), so back-to-back issue is allowed. in_ready=0 in BUSY.
- Operands and op are latched on accept; later input changes are ignored.
- Ops 0-10, 15: on accept, result is computed and registered; next cycle state=DONE, out_valid=1. Latency 1.
- Ops 11-14: on accept go to BUSY and load the counter with WIDTH.
  - One iteration per cycle; counter decrements each cycle.
  - Counter reaching 0 moves the block to DONE.
  - Accept in cycle T -> out_valid=1 in cycle T+WIDTH+1.
  - Full latency applies regardless of operand values; no early exit.
- DONE:
  - x, zero, out_valid are held stable while out_ready=0.
  - out_ready=1 with no new accept -> IDLE, out_valid=0 next cycle; x and zero keep their last value.
  - out_ready=1 with a simultaneous accept -> the new request is processed as if from IDLE.
- Divide by zero: DIVU x = all ones; REMU x = a. Same latency as any divide.
- zero = (x == 0) for every op, including reserved.
- Reset values: state=IDLE, out_valid=0, x=0, zero=0, counter=0, internal accumulators=0.
- rst asserted in any state (including mid-BUSY) aborts the operation with no result; reset values apply in the next cycle.
- rst has priority over accept.
- in_valid asserted while in_ready=0: not accepted; requester must hold the request.

Optional Feature:
- Macro: ALU_SEQ_MULDIV_EN.
- Defined: ops 11-14 behave as above, with the BUSY state, counter and mul/div datapath present.
- Undefined:
  - mul/div datapath and BUSY state are not synthesised.
  - Ops 11-14 are handled as reserved: latency 1, x=0, zero=1.
  - in_ready never deasserts except in DONE with out_ready=0.

Test Plan:
- rst=1 for 2 cycles, then op=4 (ADD), a=0xFFFFFFFF, b=1, out_ready=1 -> next cycle out_valid=1, x=0, zero=1, in_ready=1.
- op=7 (SLT), a=0xFFFFFFFE, b=1 -> x=1; op=6 (SLTU), same operands -> x=0, zero=1; op=10 (SRA), a=0x80000000, b=0x24 -> x=0xF8000000.
- MUL enabled: op=11, a=0x12345678, b=0x10 issued at T -> in_ready=0 for T+1..T+32, out_valid=1 at T+33, x=0x23456780. MULHU with the same operands -> x=0x1.
- op=13 (DIVU), a=100, b=7 -> x=14; op=14 (REMU) -> x=2; op=13, b=0 -> x=0xFFFFFFFF; op=14, a=5, b=0 -> x=5.
- Backpressure: result x=0xA5 with out_ready=0 for 5 cycles -> x, zero, out_valid stable and in_ready=0; then out_ready=1 with new in_valid (ADD 2+3) -> accepted that cycle, x=5 next cycle.
- rst asserted 10 cycles into a DIVU -> next cycle state=IDLE, out_valid=0, x=0; a following ADD 1+1 -> x=2 with latency 1.

Source files
------------

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with registered result and optional iterative mul/div (ALU_SEQ_MULDIV_EN)
module alu_seq #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x,
  output logic             zero
);

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_NOR   = 4'd2;
  localparam logic [3:0] OP_XOR   = 4'd3;
  localparam logic [3:0] OP_ADD   = 4'd4;
  localparam logic [3:0] OP_SUB   = 4'd5;
  localparam logic [3:0] OP_SLTU  = 4'd6;
  localparam logic [3:0] OP_SLT   = 4'd7;
  localparam logic [3:0] OP_SLL   = 4'd8;
  localparam logic [3:0] OP_SRL   = 4'd9;
  localparam logic [3:0] OP_SRA   = 4'd10;
`ifdef ALU_SEQ_MULDIV_EN
  localparam logic [3:0] OP_MUL   = 4'd11;
  localparam logic [3:0] OP_MULHU = 4'd12;
  localparam logic [3:0] OP_DIVU  = 4'd13;
  localparam logic [3:0] OP_REMU  = 4'd14;

  localparam int             CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  CNT_INIT = CW'(WIDTH);
`endif

  typedef enum logic [1:0] {
`ifdef ALU_SEQ_MULDIV_EN
    S_BUSY = 2'd1,
`endif
    S_IDLE = 2'd0,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  state_t            w_accept_target;
  logic              w_in_ready;
  logic              w_accept;
  logic [SHW-1:0]    w_shamt;
  logic [WIDTH-1:0]  w_alu;
  logic [WIDTH-1:0]  r_x;
  logic              r_zero;

`ifdef ALU_SEQ_MULDIV_EN
  logic [3:0]        r_op;
  logic [WIDTH-1:0]  r_opnd;
  logic [WIDTH-1:0]  r_hi;
  logic [WIDTH-1:0]  r_lo;
  logic [CW-1:0]     r_cnt;
  logic              w_is_md;
  logic              w_op_is_mul;
  logic              w_r_is_mul;
  logic              w_cnt_last;
  logic [WIDTH:0]    w_sum;
  logic [WIDTH:0]    w_shift;
  logic [WIDTH:0]    w_diff;
  logic [WIDTH-1:0]  w_hi_nxt;
  logic [WIDTH-1:0]  w_lo_nxt;
  logic [WIDTH-1:0]  w_md_res;

  assign w_op_is_mul     = (op == OP_MUL) || (op == OP_MULHU);
  assign w_is_md         = w_op_is_mul || (op == OP_DIVU) || (op == OP_REMU);
  assign w_r_is_mul      = (r_op == OP_MUL) || (r_op == OP_MULHU);
  assign w_cnt_last      = (r_cnt == CW'(1));
  assign w_accept_target = w_is_md ? S_BUSY : S_DONE;
`else
  assign w_accept_target = S_DONE;
`endif

  assign w_shamt   = b[SHW-1:0];
  assign w_accept  = in_valid & w_in_ready;
  assign in_ready  = w_in_ready;
  assign out_valid = (r_state == S_DONE);
  assign x         = r_x;
  assign zero      = r_zero;

  // Single-cycle result for the latency-1 ops; mul/div and reserved codes read as zero here
  always_comb begin
    w_alu = '0;
    case (op)
      OP_AND:  w_alu = a & b;
      OP_OR:   w_alu = a | b;
      OP_NOR:  w_alu = ~(a | b);
      OP_XOR:  w_alu = a ^ b;
      OP_ADD:  w_alu = a + b;
      OP_SUB:  w_alu = a - b;
      OP_SLTU: w_alu = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL:  w_alu = a << w_shamt;
      OP_SRL:  w_alu = a >> w_shamt;
      OP_SRA:  w_alu = $signed(a) >>> w_shamt;
      default: w_alu = '0;
    endcase
  end

  // Next-state and in_ready; DONE can hand off and accept in the same cycle
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) w_state_nxt = w_accept_target;
      end
      S_DONE: begin
        w_in_ready = out_ready;
        if (out_ready) w_state_nxt = in_valid ? w_accept_target : S_IDLE;
      end
`ifdef ALU_SEQ_MULDIV_EN
      S_BUSY: begin
        if (w_cnt_last) w_state_nxt = S_DONE;
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

`ifdef ALU_SEQ_MULDIV_EN
  // One shift-add multiply step or one restoring divide step, plus final result select
  always_comb begin
    w_sum   = {1'b0, r_hi} + ({(WIDTH+1){r_lo[0]}} & {1'b0, r_opnd});
    w_shift = {r_hi, r_lo[WIDTH-1]};
    w_diff  = w_shift - {1'b0, r_opnd};
    if (w_r_is_mul) begin
      w_hi_nxt = w_sum[WIDTH:1];
      w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
    end else if (!w_diff[WIDTH]) begin
      w_hi_nxt = w_diff[WIDTH-1:0];
      w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
    end else begin
      w_hi_nxt = w_shift[WIDTH-1:0];
      w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
    end
    case (r_op)
      OP_MUL:  w_md_res = w_lo_nxt;
      OP_MULHU: w_md_res = w_hi_nxt;
      OP_DIVU: w_md_res = w_lo_nxt;
      default: w_md_res = w_hi_nxt;
    endcase
  end
`endif

  // Operand capture, iteration and result registers; x/zero only change when a new result lands
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x    <= '0;
      r_zero <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
      r_op   <= '0;
      r_opnd <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_cnt  <= '0;
`endif
    end else if (w_accept) begin
`ifdef ALU_SEQ_MULDIV_EN
      if (w_is_md) begin
        r_op  <= op;
        r_cnt <= CNT_INIT;
        r_hi  <= '0;
        if (w_op_is_mul) begin
          r_lo   <= b;
          r_opnd <= a;
        end else begin
          r_lo   <= a;
          r_opnd <= b;
        end
      end else begin
        r_x    <= w_alu;
        r_zero <= (w_alu == '0);
      end
`else
      r_x    <= w_alu;
      r_zero <= (w_alu == '0);
`endif
    end
`ifdef ALU_SEQ_MULDIV_EN
    else if (r_state == S_BUSY) begin
      r_cnt <= r_cnt - CW'(1);
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
      if (w_cnt_last) begin
        r_x    <= w_md_res;
        r_zero <= (w_md_res == '0);
      end
    end
`endif
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq with randomized ops against an arithmetic model
module tb_alu_seq;

  localparam int W = 32;
`ifdef ALU_SEQ_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    op = '0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  x;
  logic          zero;

  int            checks = 0;
  int            errors = 0;
  logic [W-1:0]  exp_q[$];
  bit            rand_ready = 1'b0;
  bit            fixed_ready = 1'b1;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .x(x), .zero(zero)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(input logic [3:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb);
    logic [2*W-1:0] p;
    int sh;
    p  = {{W{1'b0}}, aa} * {{W{1'b0}}, bb};
    sh = int'(bb[4:0]);
    case (o)
      4'd0:  return aa & bb;
      4'd1:  return aa | bb;
      4'd2:  return ~(aa | bb);
      4'd3:  return aa ^ bb;
      4'd4:  return aa + bb;
      4'd5:  return aa - bb;
      4'd6:  return (aa < bb) ? 32'd1 : 32'd0;
      4'd7:  return ($signed(aa) < $signed(bb)) ? 32'd1 : 32'd0;
      4'd8:  return aa << sh;
      4'd9:  return aa >> sh;
      4'd10: return $signed(aa) >>> sh;
      4'd11: return MD_EN ? p[W-1:0] : '0;
      4'd12: return MD_EN ? p[2*W-1:W] : '0;
      4'd13: return !MD_EN ? '0 : (bb == 0) ? '1 : aa / bb;
      4'd14: return !MD_EN ? '0 : (bb == 0) ? aa : aa % bb;
      default: return '0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // out_ready generator, updated at posedge+2 so main-process changes at posedge+1 take effect in the same cycle
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : fixed_ready;
    end
  end

  // Monitor: every presented result is compared against the scoreboard head, popped on handshake
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result actual x=%h with empty scoreboard", x);
        end else begin
          if (x !== exp_q[0] || zero !== (exp_q[0] == '0)) begin
            errors++;
            $display("FAIL result actual x=%h zero=%b required x=%h zero=%b",
                     x, zero, exp_q[0], (exp_q[0] == '0));
          end
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance
  task automatic issue(input logic [3:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input bit push, output int waited);
    op = o; a = aa; b = bb; in_valid = 1'b1;
    waited = 0;
    while (waited <= 200) begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      @(posedge clk);
      #1;
    end
    if (waited > 200) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout op=%0d actual in_ready=%b required 1", o, in_ready);
    end else if (push) begin
      exp_q.push_back(model(o, aa, bb));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 4'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic lat_check(input logic [3:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb);
    int  w, n, exp_lat;
    bit  rdy;
    exp_lat = (MD_EN && o >= 4'd11 && o <= 4'd14) ? W : 0;
    issue(o, aa, bb, 1'b1, w);
    n = 0;
    rdy = 1'b0;
    while (n <= 100) begin
      @(negedge clk);
      if (out_valid) break;
      if (in_ready) rdy = 1'b1;
      n++;
    end
    chk($sformatf("latency_op%0d", o), n, exp_lat);
    chk($sformatf("busy_in_ready_op%0d", o), {31'd0, rdy}, 32'd0);
    chk($sformatf("done_in_ready_op%0d", o), {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w, n;
    logic [3:0] ro;
    logic [W-1:0] ra, rb;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_x", x, 32'd0);
    chk("reset_zero", {31'd0, zero}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    lat_check(4'd4,  32'hFFFF_FFFF, 32'd1);
    lat_check(4'd7,  32'hFFFF_FFFE, 32'd1);
    lat_check(4'd6,  32'hFFFF_FFFE, 32'd1);
    lat_check(4'd10, 32'h8000_0000, 32'h24);
    lat_check(4'd11, 32'h1234_5678, 32'h10);
    lat_check(4'd12, 32'h1234_5678, 32'h10);
    lat_check(4'd13, 32'd100, 32'd7);
    lat_check(4'd14, 32'd100, 32'd7);
    lat_check(4'd13, 32'd100, 32'd0);
    lat_check(4'd14, 32'd5,   32'd0);
    lat_check(4'd15, 32'd9,   32'd9);

    // Backpressure: result held with out_ready low, then hand-off and new accept in the same cycle
    fixed_ready = 1'b0;
    issue(4'd1, 32'hA5, 32'h0, 1'b1, w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    fixed_ready = 1'b1;
    issue(4'd4, 32'd2, 32'd3, 1'b1, w);
    chk("bp_accept_wait", w, 32'd0);
    @(negedge clk);
    chk("bp_next_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;

    // Reset in the middle of a divide aborts it
    issue(4'd13, 32'd1000, 32'd3, !MD_EN, w);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_x", x, 32'd0);
    chk("abort_zero", {31'd0, zero}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    issue(4'd4, 32'd1, 32'd1, 1'b1, w);
    @(negedge clk);
    chk("post_abort_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;

    // Randomized traffic with random consumer backpressure
    rand_ready = 1'b1;
    for (int k = 0; k < 150; k++) begin
      ro = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 4) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
      case ($urandom_range(0, 3))
        0: rb = '0;
        1: rb = W'($urandom_range(1, 40));
        default: rb = W'($urandom);
      endcase
      issue(ro, ra, rb, 1'b1, w);
      n = $urandom_range(0, 2);
      if (n > 0) begin
        repeat (n) @(posedge clk);
        #1;
      end
    end
    rand_ready = 1'b0;
    fixed_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
